// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Two-requester write-port arbiter for the 4 x 16-bit register file.
// Requester A (ALU writeback) and requester B (load writeback) share one
// registered RegWrite/RD/WriteData triple through valid/ready handshakes.
// Build option: define RFARB_ROUND_ROBIN_EN for round-robin arbitration;
// when it is undefined, A has fixed priority and B can starve.
module regfile_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  Stall,

    input  logic                  ReqA_Valid,
    input  logic [ADDR_WIDTH-1:0] ReqA_Addr,
    input  logic [DATA_WIDTH-1:0] ReqA_Data,
    output logic                  ReqA_Ready,

    input  logic                  ReqB_Valid,
    input  logic [ADDR_WIDTH-1:0] ReqB_Addr,
    input  logic [DATA_WIDTH-1:0] ReqB_Data,
    output logic                  ReqB_Ready,

    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] RD,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  LastGrant
);

    // Priority pointer: 0 = A wins contention, 1 = B wins contention
    logic                  prio;
    logic                  xfer_a;
    logic                  xfer_b;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Grant: Ready looks only at Valid, Stall, ResetN and prio, never at Addr/Data
    always_comb begin
        ReqA_Ready = 1'b0;
        ReqB_Ready = 1'b0;
        if (ResetN && !Stall) begin
            if (ReqA_Valid && ReqB_Valid) begin
                ReqA_Ready = ~prio;
                ReqB_Ready = prio;
            end else begin
                ReqA_Ready = ReqA_Valid;
                ReqB_Ready = ReqB_Valid;
            end
        end
    end

    // Winner select; the grant logic guarantees at most one transfer per cycle
    always_comb begin
        xfer_a   = ReqA_Valid & ReqA_Ready;
        xfer_b   = ReqB_Valid & ReqB_Ready;
        xfer     = xfer_a | xfer_b;
        sel_addr = xfer_b ? ReqB_Addr : ReqA_Addr;
        sel_data = xfer_b ? ReqB_Data : ReqA_Data;
    end

    // Output register: R0 writes are consumed but never raise RegWrite
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
            LastGrant <= 1'b0;
        end else begin
            RegWrite <= xfer && (sel_addr != '0);
            if (xfer) begin
                RD        <= sel_addr;
                WriteData <= sel_data;
                LastGrant <= xfer_b;
            end
        end
    end

`ifdef RFARB_ROUND_ROBIN_EN
    // Round-robin: after a transfer, point at the requester that did not win
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            prio <= 1'b0;
        end else if (xfer) begin
            prio <= xfer_a;
        end
    end
`else
    // Fixed priority: A always wins contention
    assign prio = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed test of regfile_write_arbiter with a small register-file model
// that captures RegWrite/RD/WriteData on each rising edge (R0 stays zero).
module tb_regfile_write_arbiter;

    localparam bit RR =
`ifdef RFARB_ROUND_ROBIN_EN
        1'b1;
`else
        1'b0;
`endif

    logic        Clock;
    logic        ResetN;
    logic        Stall;
    logic        ReqA_Valid;
    logic [1:0]  ReqA_Addr;
    logic [15:0] ReqA_Data;
    logic        ReqA_Ready;
    logic        ReqB_Valid;
    logic [1:0]  ReqB_Addr;
    logic [15:0] ReqB_Data;
    logic        ReqB_Ready;
    logic        RegWrite;
    logic [1:0]  RD;
    logic [15:0] WriteData;
    logic        LastGrant;

    logic [15:0] rf [4];
    int          total;
    int          bad;

    regfile_write_arbiter #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(2)
    ) dut (
        .Clock      (Clock),
        .ResetN     (ResetN),
        .Stall      (Stall),
        .ReqA_Valid (ReqA_Valid),
        .ReqA_Addr  (ReqA_Addr),
        .ReqA_Data  (ReqA_Data),
        .ReqA_Ready (ReqA_Ready),
        .ReqB_Valid (ReqB_Valid),
        .ReqB_Addr  (ReqB_Addr),
        .ReqB_Data  (ReqB_Data),
        .ReqB_Ready (ReqB_Ready),
        .RegWrite   (RegWrite),
        .RD         (RD),
        .WriteData  (WriteData),
        .LastGrant  (LastGrant)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Register-file model downstream of the write port
    always @(posedge Clock) begin
        if (RegWrite && RD != 2'd0) rf[RD] <= WriteData;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic exp_b;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 4; i++) rf[i] = 16'h0000;
        ResetN = 1'b0;
        Stall = 1'b0;
        ReqA_Valid = 1'b1; ReqA_Addr = 2'd1; ReqA_Data = 16'h1111;
        ReqB_Valid = 1'b1; ReqB_Addr = 2'd2; ReqB_Data = 16'h2222;

        // Reset state, with both Valids held high
        #2;
        check("rst_regwrite", RegWrite, 0);
        check("rst_rd", RD, 0);
        check("rst_wdata", WriteData, 0);
        check("rst_lastgrant", LastGrant, 0);
        check("rst_ready_a", ReqA_Ready, 0);
        check("rst_ready_b", ReqB_Ready, 0);
        step();
        check("rst_hold_regwrite", RegWrite, 0);
        check("rst_hold_ready_a", ReqA_Ready, 0);
        ReqA_Valid = 1'b0;
        ReqB_Valid = 1'b0;
        ResetN = 1'b1;
        step();

        // Single requester A: R2 <= 0x1234
        ReqA_Valid = 1'b1; ReqA_Addr = 2'd2; ReqA_Data = 16'h1234;
        #1;
        check("single_ready_a", ReqA_Ready, 1);
        check("single_ready_b", ReqB_Ready, 0);
        step();
        ReqA_Valid = 1'b0;
        check("single_regwrite", RegWrite, 1);
        check("single_rd", RD, 2);
        check("single_wdata", WriteData, 16'h1234);
        check("single_lastgrant", LastGrant, 0);
        step();
        check("single_rf2", rf[2], 16'h1234);
        check("single_regwrite_drop", RegWrite, 0);
        check("single_rd_hold", RD, 2);
        check("single_wdata_hold", WriteData, 16'h1234);

        // R0 write from B: consumed, but RegWrite stays low
        ReqB_Valid = 1'b1; ReqB_Addr = 2'd0; ReqB_Data = 16'hFFFF;
        #1;
        check("r0_ready_b", ReqB_Ready, 1);
        step();
        ReqB_Valid = 1'b0;
        check("r0_lastgrant", LastGrant, 1);
        check("r0_regwrite", RegWrite, 0);
        check("r0_rd", RD, 0);
        check("r0_wdata", WriteData, 16'hFFFF);
        step();
        check("r0_regwrite_after", RegWrite, 0);
        check("r0_rf0", rf[0], 0);

        // Contention on R1 for 4 cycles
        ReqA_Valid = 1'b1; ReqA_Addr = 2'd1; ReqA_Data = 16'h00AA;
        ReqB_Valid = 1'b1; ReqB_Addr = 2'd1; ReqB_Data = 16'h00BB;
        for (int i = 0; i < 4; i++) begin
            exp_b = RR ? i[0] : 1'b0;
            #1;
            check("cont_ready_a", ReqA_Ready, !exp_b);
            check("cont_ready_b", ReqB_Ready, exp_b);
            step();
            check("cont_lastgrant", LastGrant, exp_b);
            check("cont_regwrite", RegWrite, 1);
            check("cont_wdata", WriteData, exp_b ? 16'h00BB : 16'h00AA);
        end
        // A drops: B wins on that very cycle
        ReqA_Valid = 1'b0;
        #1;
        check("cont_drop_ready_b", ReqB_Ready, 1);
        step();
        ReqB_Valid = 1'b0;
        check("cont_drop_lastgrant", LastGrant, 1);
        check("cont_drop_wdata", WriteData, 16'h00BB);
        step();
        check("cont_rf1", rf[1], 16'h00BB);

        // Stall: a write accepted before Stall still pulses
        ReqA_Valid = 1'b1; ReqA_Addr = 2'd2; ReqA_Data = 16'h0F0F;
        step();
        Stall = 1'b1;
        ReqA_Addr = 2'd3; ReqA_Data = 16'h5A5A;
        #1;
        check("stall_inflight_regwrite", RegWrite, 1);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready_a", ReqA_Ready, 0);
            step();
            check("stall_regwrite", RegWrite, 0);
        end
        check("stall_rf2", rf[2], 16'h0F0F);
        Stall = 1'b0;
        #1;
        check("unstall_ready_a", ReqA_Ready, 1);
        step();
        ReqA_Valid = 1'b0;
        check("unstall_regwrite", RegWrite, 1);
        check("unstall_rd", RD, 3);
        check("unstall_wdata", WriteData, 16'h5A5A);
        step();
        check("unstall_rf3", rf[3], 16'h5A5A);

        // Mid-run reset drops the in-flight write to R1
        ReqB_Valid = 1'b1; ReqB_Addr = 2'd1; ReqB_Data = 16'h7777;
        step();
        check("mrst_pre_regwrite", RegWrite, 1);
        ReqA_Valid = 1'b1; ReqA_Addr = 2'd2; ReqA_Data = 16'h4444;
        ResetN = 1'b0;
        #1;
        check("mrst_regwrite", RegWrite, 0);
        check("mrst_rd", RD, 0);
        check("mrst_wdata", WriteData, 0);
        check("mrst_lastgrant", LastGrant, 0);
        check("mrst_ready_a", ReqA_Ready, 0);
        check("mrst_ready_b", ReqB_Ready, 0);
        step();
        check("mrst_rf1", rf[1], 16'h00BB);
        ResetN = 1'b1;
        #1;
        check("mrst_rearb_ready_a", ReqA_Ready, 1);
        check("mrst_rearb_ready_b", ReqB_Ready, 0);
        step();
        ReqA_Valid = 1'b0;
        ReqB_Valid = 1'b0;
        check("mrst_rearb_lastgrant", LastGrant, 0);
        check("mrst_rearb_wdata", WriteData, 16'h4444);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
